cve2_iter_divider: RTL and testbench

//  Sequential 32-bit RISC-V integer divider; the responder side of the EX stage's

---
 rtl/cve2_iter_divider.sv | 152 +++++++++++++++
 tb/tb_cve2_iter_divider.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cve2_iter_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle, offload-style
// valid/ready/flush handshake with the EX stage, result held until taken.
module cve2_iter_divider #(
    parameter int unsigned Width    = 32,
    parameter int unsigned TagWidth = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [Width-1:0]    op_a_i,
    input  logic [Width-1:0]    op_b_i,
    input  logic [1:0]          op_i,
    input  logic [TagWidth-1:0] tag_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                flush_i,
    output logic [Width-1:0]    result_o,
    output logic [TagWidth-1:0] tag_o,
    output logic                div_zero_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                busy_o
);

    localparam int unsigned CntW = $clog2(Width);
    localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [Width-1:0]     rem_q, rem_d;
    logic [Width-1:0]     dvd_q, dvd_d;
    logic [Width-1:0]     div_q, div_d;
    logic                 neg_q, neg_d;
    logic                 is_rem_q, is_rem_d;
    logic [TagWidth-1:0]  tag_q, tag_d;
    logic [Width-1:0]     result_q, result_d;
    logic                 dz_q, dz_d;

    logic                 signed_op, a_neg, b_neg, b_zero, ovf;
    logic [Width-1:0]     abs_a, abs_b;
    logic [Width:0]       shifted;
    logic [Width+1:0]     trial;
    logic                 borrow;
    logic [Width-1:0]     rem_next, quo_next, fin_raw, fin_val;

    always_comb begin
        signed_op = ~op_i[0];
        a_neg     = signed_op & op_a_i[Width-1];
        b_neg     = signed_op & op_b_i[Width-1];
        abs_a     = a_neg ? -op_a_i : op_a_i;
        abs_b     = b_neg ? -op_b_i : op_b_i;
        b_zero    = (op_b_i == '0);
        ovf       = signed_op & (op_a_i == MinVal) & (op_b_i == '1);

        // Partial remainder stays below the divisor, so a non-borrowing difference fits Width bits.
        shifted   = {rem_q, dvd_q[Width-1]};
        trial     = {1'b0, shifted} - {2'b00, div_q};
        borrow    = trial[Width+1];
        rem_next  = borrow ? shifted[Width-1:0] : trial[Width-1:0];
        quo_next  = {dvd_q[Width-2:0], ~borrow};
        fin_raw   = is_rem_q ? rem_next : quo_next;
        fin_val   = neg_q ? -fin_raw : fin_raw;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        div_d    = div_q;
        neg_d    = neg_q;
        is_rem_d = is_rem_q;
        tag_d    = tag_q;
        result_d = result_q;
        dz_d     = dz_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i && !flush_i) begin
                    tag_d    = tag_i;
                    is_rem_d = op_i[1];
                    neg_d    = op_i[1] ? a_neg : (a_neg ^ b_neg);
                    dz_d     = 1'b0;
                    if (b_zero) begin
                        result_d = op_i[1] ? op_a_i : '1;
                        dz_d     = 1'b1;
                        state_d  = StDone;
                    end else if (ovf) begin
                        result_d = op_i[1] ? '0 : MinVal;
                        state_d  = StDone;
                    end else begin
                        rem_d   = '0;
                        dvd_d   = abs_a;
                        div_d   = abs_b;
                        cnt_d   = CntW'(Width - 1);
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d = rem_next;
                dvd_d = quo_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    result_d = fin_val;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (flush_i) state_d = StIdle;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            div_q    <= '0;
            neg_q    <= 1'b0;
            is_rem_q <= 1'b0;
            tag_q    <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            div_q    <= div_d;
            neg_q    <= neg_d;
            is_rem_q <= is_rem_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            dz_q     <= dz_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign out_valid_o = (state_q == StDone);
    assign result_o    = result_q;
    assign tag_o       = tag_q;
    assign div_zero_o  = dz_q;

endmodule

// File: tb/tb_cve2_iter_divider.sv
// Directed checks of cve2_iter_divider: latency, signed fix-ups, special cases, flush, reset,
// plus a short run against a behavioural reference with output stalls.
module tb_cve2_iter_divider;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] op_a_i, op_b_i;
    logic [1:0]  op_i;
    logic        tag_i;
    logic        in_valid_i, in_ready_o, flush_i;
    logic [31:0] result_o;
    logic        tag_o, div_zero_o, out_valid_o, out_ready_i, busy_o;

    int total = 0;
    int bad   = 0;

    cve2_iter_divider #(.Width(32), .TagWidth(1)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .op_i        (op_i),
        .tag_i       (tag_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .flush_i     (flush_i),
        .result_o    (result_o),
        .tag_o       (tag_o),
        .div_zero_o  (div_zero_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return 32'($signed(a) / $signed(b));
            2'b01:   return a / b;
            2'b10:   return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    // Accept one request, check exact latency, optional hold with out_ready_i low, then retire.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic tg, input logic [31:0] exp, input logic exp_dz,
                         input bit special, input int hold);
        chk("in_ready_idle", in_ready_o, 1);
        op_i = op; op_a_i = a; op_b_i = b; tag_i = tg; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        op_a_i = $urandom; op_b_i = $urandom; op_i = 2'($urandom); tag_i = ~tg;
        if (!special) begin
            chk("busy_calc", busy_o, 1);
            chk("in_ready_calc", in_ready_o, 0);
            repeat (31) @(posedge clk_i);
            #1 chk("valid_early", out_valid_o, 0);
            @(posedge clk_i); #1;
        end
        chk("out_valid", out_valid_o, 1);
        chk("result", result_o, exp);
        chk("div_zero", div_zero_o, exp_dz);
        chk("tag", tag_o, tg);
        chk("in_ready_done", in_ready_o, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk_i); #1;
            chk("hold_valid", out_valid_o, 1);
            chk("hold_result", result_o, exp);
            chk("hold_tag", tag_o, tg);
        end
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        chk("retired_valid", out_valid_o, 0);
        chk("retired_in_ready", in_ready_o, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic        seen_valid;
        logic [1:0]  rop;
        logic [31:0] ra, rb, rexp;
        logic        rtag;
        int          cyc, stall;

        rst_i = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
        op_a_i = '0; op_b_i = '0; op_i = '0; tag_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_tag", tag_o, 0);
        chk("rst_dz", div_zero_o, 0);

        do_op(2'b01, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, 0, 3);
        do_op(2'b11, 32'd100, 32'd7, 1'b0, 32'd2, 1'b0, 0, 0);

        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 1'b0, 0, 0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 1'b0, 0, 0);
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd1, 1'b0, 0, 0);

        do_op(2'b00, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1, 1);
        do_op(2'b11, 32'd5, 32'd0, 1'b0, 32'd5, 1'b1, 1, 0);

        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1, 0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0, 1, 0);

        // Flush coincident with a request in IDLE accepts nothing.
        op_i = 2'b01; op_a_i = 32'd50; op_b_i = 32'd5; in_valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_idle_busy", busy_o, 0);

        // Flush in the middle of CALC.
        op_i = 2'b01; op_a_i = 32'd1000; op_b_i = 32'd3; tag_i = 1'b0; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1 flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        chk("flush_busy", busy_o, 0);
        chk("flush_in_ready", in_ready_o, 1);
        seen_valid = out_valid_o;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk_i); #1;
            seen_valid = seen_valid | out_valid_o;
        end
        chk("flush_no_valid", seen_valid, 0);
        do_op(2'b01, 32'd9, 32'd3, 1'b1, 32'd3, 1'b0, 0, 0);

        // Reset while a result waits in DONE.
        op_i = 2'b00; op_a_i = 32'd77; op_b_i = 32'd0; tag_i = 1'b1; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        chk("pre_rst_valid", out_valid_o, 1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("mid_rst_valid", out_valid_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_result", result_o, 0);
        chk("mid_rst_tag", tag_o, 0);
        chk("mid_rst_dz", div_zero_o, 0);
        chk("mid_rst_in_ready", in_ready_o, 1);

        for (int i = 0; i < 10; i++) begin
            rop  = 2'($urandom);
            ra   = $urandom;
            rb   = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i == 4) rb = 32'd0;
            if (i % 4 == 1) ra = -ra;
            rtag = 1'($urandom);
            rexp = ref_div(rop, ra, rb);
            op_i = rop; op_a_i = ra; op_b_i = rb; tag_i = rtag; in_valid_i = 1'b1;
            @(posedge clk_i); #1;
            in_valid_i = 1'b0;
            op_a_i = $urandom; op_b_i = $urandom;
            cyc = 0;
            while (!out_valid_o && cyc < 40) begin
                @(posedge clk_i); #1;
                cyc++;
            end
            chk("rnd_valid", out_valid_o, 1);
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk_i); #1;
                chk("rnd_stall_valid", out_valid_o, 1);
            end
            chk("rnd_result", result_o, rexp);
            chk("rnd_dz", div_zero_o, (rb == 32'd0));
            chk("rnd_tag", tag_o, rtag);
            out_ready_i = 1'b1;
            @(posedge clk_i); #1;
            out_ready_i = 1'b0;
            chk("rnd_retired", out_valid_o, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
